// File: rtl/upsample_win_ctrl.sv
// upsample_win_ctrl: line-buffer ring scheduler for the 4x4-window
// 2x upsampling conv; no pixel data passes through this block.

module upsample_win_ctrl #(
  parameter int IMG_WIDTH    = 1920,
  parameter int NUM_LB       = 5,
  parameter int CONV_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_frame_start,
  input  logic       i_pixel_valid,
  output logic       o_in_ready,
  output logic [4:0] o_lb_wr_sel,
  output logic [2:0] o_lb_rd_sel,
  output logic       o_lb_rd_en,
  input  logic       i_out_ready,
  output logic       o_conv_en,
  input  logic       i_conv_valid,
  output logic       o_line_done,
  output logic       o_err
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int VW = $clog2(IMG_WIDTH + 1) + 1;
  localparam int DW = $clog2(CONV_LATENCY + 2);

  localparam logic [CW-1:0] W_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [VW-1:0] W_FULL = VW'(IMG_WIDTH);
  localparam logic [DW-1:0] D_LAST = DW'(CONV_LATENCY);
  localparam logic [2:0]    LB_N   = 3'(NUM_LB);
  localparam logic [2:0]    LB_WIN = 3'(NUM_LB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      wr_sel_q, wr_sel_d;
  logic [2:0]      rd_sel_q, rd_sel_d;
  logic [2:0]      stored_q, stored_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [VW-1:0]   vld_cnt_q, vld_cnt_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic            rd_en_q, rd_en_d;
  logic            conv_en_q, conv_en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            px_acc;
  logic            line_wr;
  logic            rd_last;
  logic            rel_line;
  logic [VW-1:0]   vld_tot;
  logic            vld_over;

  assign o_in_ready = (stored_q < LB_N);

  assign px_acc   = i_pixel_valid && o_in_ready;
  assign line_wr  = px_acc && (wr_cnt_q == W_LAST);
  // rd_cnt counts strobes already on the output; the last one is visible
  assign rd_last  = rd_en_q && (rd_cnt_q == W_LAST);
  assign rel_line = (state_q == DRAIN) && (drn_q == D_LAST);
  assign vld_tot  = vld_cnt_q + VW'(i_conv_valid);
  assign vld_over = (vld_tot > W_FULL);

  always_comb begin
    state_d   = state_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    stored_d  = stored_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    vld_cnt_d = vld_cnt_q;
    drn_d     = drn_q;
    rd_en_d   = 1'b0;
    conv_en_d = rd_en_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (px_acc) begin
      wr_cnt_d = line_wr ? '0 : wr_cnt_q + CW'(1);
      if (line_wr) begin
        wr_sel_d = {wr_sel_q[3:0], wr_sel_q[4]};
      end
    end

    if (line_wr && !rel_line) begin
      stored_d = stored_q + 3'd1;
    end else if (rel_line && !line_wr) begin
      stored_d = stored_q - 3'd1;
    end

    if (vld_over) begin
      err_d = 1'b1;
    end else begin
      vld_cnt_d = vld_tot;
    end

    unique case (state_q)
      IDLE: begin
        if (stored_q >= LB_WIN) begin
          state_d  = RD;
          rd_cnt_d = '0;
        end
      end
      RD: begin
        rd_en_d = i_out_ready && !rd_last;
        if (rd_last) begin
          state_d  = DRAIN;
          rd_cnt_d = '0;
          drn_d    = '0;
        end else if (rd_en_q) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        drn_d = drn_q + DW'(1);
        // the return arriving this cycle is part of the line total
        if (rel_line) begin
          state_d   = IDLE;
          drn_d     = '0;
          rd_sel_d  = (rd_sel_q == 3'd4) ? 3'd0 : rd_sel_q + 3'd1;
          done_d    = 1'b1;
          err_d     = err_q | vld_over | (vld_tot != W_FULL);
          vld_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wr_sel_q  <= 5'b00001;
      rd_sel_q  <= 3'd0;
      stored_q  <= 3'd0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      vld_cnt_q <= '0;
      drn_q     <= '0;
      rd_en_q   <= 1'b0;
      conv_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (i_frame_start) begin
      state_q   <= IDLE;
      wr_sel_q  <= 5'b00001;
      rd_sel_q  <= 3'd0;
      stored_q  <= 3'd0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      vld_cnt_q <= '0;
      drn_q     <= '0;
      rd_en_q   <= 1'b0;
      conv_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      stored_q  <= stored_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      vld_cnt_q <= vld_cnt_d;
      drn_q     <= drn_d;
      rd_en_q   <= rd_en_d;
      conv_en_q <= conv_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_lb_wr_sel = wr_sel_q;
  assign o_lb_rd_sel = rd_sel_q;
  assign o_lb_rd_en  = rd_en_q;
  assign o_conv_en   = conv_en_q;
  assign o_line_done = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_upsample_win_ctrl.sv
// tb_upsample_win_ctrl: directed bench with an event-level model of
// the window scheduler, checked every cycle, plus literal spot checks.

module tb_upsample_win_ctrl;

  localparam int W  = 8;
  localparam int CL = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_frame_start = 1'b0;
  logic       i_pixel_valid = 1'b0;
  logic       i_out_ready = 1'b0;
  logic       i_conv_valid = 1'b0;
  logic       o_in_ready;
  logic [4:0] o_lb_wr_sel;
  logic [2:0] o_lb_rd_sel;
  logic       o_lb_rd_en;
  logic       o_conv_en;
  logic       o_line_done;
  logic       o_err;

  upsample_win_ctrl #(
    .IMG_WIDTH   (W),
    .NUM_LB      (5),
    .CONV_LATENCY(CL)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_frame_start(i_frame_start),
    .i_pixel_valid(i_pixel_valid),
    .o_in_ready   (o_in_ready),
    .o_lb_wr_sel  (o_lb_wr_sel),
    .o_lb_rd_sel  (o_lb_rd_sel),
    .o_lb_rd_en   (o_lb_rd_en),
    .i_out_ready  (i_out_ready),
    .o_conv_en    (o_conv_en),
    .i_conv_valid (i_conv_valid),
    .o_line_done  (o_line_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // conv stand-in: valid echoes conv_en two cycles later
  logic c1 = 1'b0, c2 = 1'b0;
  bit drop_req = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      c1 = 1'b0;
      c2 = 1'b0;
    end else begin
      c2 = c1;
      c1 = o_conv_en;
    end
  end
  always @(posedge clk) begin
    #1;
    if (!rstn) i_conv_valid = 1'b0;
    else if (c2 && drop_req) begin
      i_conv_valid = 1'b0;
      drop_req = 1'b0;
    end else i_conv_valid = c2;
  end

  bit tog = 1'b0;
  always @(posedge clk) begin
    #1;
    if (tog) i_out_ready = !i_out_ready;
  end

  // model: lines held, pixel position, ring slots, read job progress
  int cyc = 0;
  int m_stored = 0, m_wpix = 0, m_wbuf = 0, m_top = 0;
  int m_mode = 0, m_iss = 0, m_dedge = 0, m_vld = 0;
  bit m_err = 0, m_rd = 0, m_cen = 0, m_done = 0;

  task automatic m_reset();
    m_stored = 0; m_wpix = 0; m_wbuf = 0; m_top = 0;
    m_mode = 0; m_iss = 0; m_dedge = 0; m_vld = 0;
    m_err = 0; m_rd = 0; m_cen = 0; m_done = 0;
  endtask

  task automatic m_step();
    bit acc, lw, rel, rd_old;
    acc = i_pixel_valid && (m_stored < 5);
    lw = acc && (m_wpix == W - 1);
    rel = (m_mode == 2) && (cyc == m_dedge + CL + 1);
    rd_old = m_rd;
    m_cen = m_rd;
    m_done = rel;
    m_rd = 0;
    m_vld += int'(i_conv_valid);
    if (m_vld > W) m_err = 1;
    case (m_mode)
      0: if (m_stored >= 4) begin m_mode = 1; m_iss = 0; end
      1: begin
        if (rd_old && m_iss == W) begin
          m_mode = 2;
          m_dedge = cyc;
        end else if (i_out_ready && m_iss < W) begin
          m_rd = 1;
          m_iss++;
        end
      end
      default: if (rel) begin
        m_mode = 0;
        m_top = (m_top + 1) % 5;
        if (m_vld != W) m_err = 1;
        m_vld = 0;
      end
    endcase
    if (acc) m_wpix = lw ? 0 : m_wpix + 1;
    if (lw) m_wbuf = (m_wbuf + 1) % 5;
    m_stored += int'(lw) - int'(rel);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_reset();
    else begin
      cyc++;
      if (i_frame_start) m_reset();
      else m_step();
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(o_in_ready), 32'(m_stored < 5));
    chk("wr_sel", 32'(o_lb_wr_sel), 32'(1) << m_wbuf);
    chk("rd_sel", 32'(o_lb_rd_sel), 32'(m_top));
    chk("rd_en", 32'(o_lb_rd_en), 32'(m_rd));
    chk("conv_en", 32'(o_conv_en), 32'(m_cen));
    chk("line_done", 32'(o_line_done), 32'(m_done));
    chk("err", 32'(o_err), 32'(m_err));
  end

  int n_rd = 0, n_cen = 0, n_done = 0;
  int f_rd = -1, f_cen = -1, f_done = -1;
  always @(negedge clk) begin
    if (o_lb_rd_en) begin n_rd++; if (f_rd < 0) f_rd = cyc; end
    if (o_conv_en) begin n_cen++; if (f_cen < 0) f_cen = cyc; end
    if (o_line_done) begin n_done++; if (f_done < 0) f_done = cyc; end
  end

  task automatic clr_cnt();
    n_rd = 0; n_cen = 0; n_done = 0;
    f_rd = -1; f_cen = -1; f_done = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    i_pixel_valid = 1'b0;
    i_frame_start = 1'b1;
    tick(1);
    i_frame_start = 1'b0;
  endtask

  task automatic push(input int n);
    int got = 0, guard = 0;
    bit rdy;
    i_pixel_valid = 1'b1;
    while (got < n && guard < 400) begin
      rdy = o_in_ready;
      @(posedge clk);
      if (rdy) got++;
      guard++;
      #1;
    end
    chk("push_count", 32'(got), 32'(n));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      if (o_line_done) seen = 1'b1;
      k++;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  logic [4:0] sel_tab [4] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};
  int nedge;
  int k3;

  initial begin
    tick(2);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(o_in_ready), 32'd1);
    chk("rst_wr_sel", 32'(o_lb_wr_sel), 32'd1);
    chk("rst_rd_sel", 32'(o_lb_rd_sel), 32'd0);
    chk("rst_rd_en", 32'(o_lb_rd_en), 32'd0);
    chk("rst_conv_en", 32'(o_conv_en), 32'd0);
    chk("rst_done", 32'(o_line_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    tick(1);

    // fill four lines with downstream ready
    frame();
    i_out_ready = 1'b1;
    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      push(W);
      chk("fill_wr_sel", 32'(o_lb_wr_sel), 32'(sel_tab[i]));
    end
    nedge = cyc;
    i_pixel_valid = 1'b0;
    tick(20);
    chk("fill_rd_lat", 32'(f_rd - nedge), 32'd2);
    chk("fill_cen_lat", 32'(f_cen - nedge), 32'd3);
    chk("fill_done_lat", 32'(f_done - nedge), 32'd13);
    chk("fill_n_rd", 32'(n_rd), 32'd8);
    chk("fill_n_cen", 32'(n_cen), 32'd8);
    chk("fill_n_done", 32'(n_done), 32'd1);
    chk("fill_rd_sel", 32'(o_lb_rd_sel), 32'd1);
    chk("fill_err", 32'(o_err), 32'd0);

    // backpressure: ring fills to five lines, no reads
    frame();
    i_out_ready = 1'b0;
    clr_cnt();
    push(5 * W);
    i_pixel_valid = 1'b0;
    chk("bp_in_ready", 32'(o_in_ready), 32'd0);
    chk("bp_wr_sel", 32'(o_lb_wr_sel), 32'd1);
    tick(5);
    chk("bp_n_rd", 32'(n_rd), 32'd0);
    chk("bp_hold_ready", 32'(o_in_ready), 32'd0);
    i_out_ready = 1'b1;
    wait_done(60);
    chk("bp_ready_back", 32'(o_in_ready), 32'd1);
    chk("bp_wr_sel_rel", 32'(o_lb_wr_sel), 32'd1);
    chk("bp_rd_sel", 32'(o_lb_rd_sel), 32'd1);

    // sixth line completes on the same edge as the second release
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    i_pixel_valid = 1'b1;
    repeat (W) @(posedge clk);
    #1;
    i_pixel_valid = 1'b0;
    chk("sim_done", 32'(o_line_done), 32'd1);
    chk("sim_ready", 32'(o_in_ready), 32'd1);
    chk("sim_wr_sel", 32'(o_lb_wr_sel), 32'd2);
    chk("sim_rd_sel", 32'(o_lb_rd_sel), 32'd2);
    tick(2);
    chk("sim_next_rd", 32'(o_lb_rd_en), 32'd1);
    tick(20);

    // toggling downstream ready
    frame();
    i_out_ready = 1'b1;
    clr_cnt();
    tog = 1'b1;
    push(4 * W);
    i_pixel_valid = 1'b0;
    tick(40);
    tog = 1'b0;
    i_out_ready = 1'b1;
    chk("tog_n_rd", 32'(n_rd), 32'd8);
    chk("tog_n_done", 32'(n_done), 32'd1);
    chk("tog_err", 32'(o_err), 32'd0);

    // one lost conv return makes err stick
    drop_req = 1'b1;
    push(W);
    i_pixel_valid = 1'b0;
    wait_done(60);
    chk("drop_err", 32'(o_err), 32'd1);
    tick(10);
    chk("drop_sticky", 32'(o_err), 32'd1);
    frame();
    chk("drop_clear", 32'(o_err), 32'd0);

    // async reset during the third read strobe
    clr_cnt();
    push(4 * W);
    i_pixel_valid = 1'b0;
    k3 = 0;
    for (int g = 0; g < 50 && k3 < 3; g++) begin
      @(negedge clk);
      if (o_lb_rd_en) k3++;
    end
    chk("abort_reach", 32'(k3), 32'd3);
    #1;
    rstn = 1'b0;
    #1;
    chk("abort_rd_en", 32'(o_lb_rd_en), 32'd0);
    chk("abort_conv_en", 32'(o_conv_en), 32'd0);
    chk("abort_done", 32'(o_line_done), 32'd0);
    chk("abort_ready", 32'(o_in_ready), 32'd1);
    clr_cnt();
    tick(2);
    rstn = 1'b1;
    tick(25);
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_no_rd", 32'(n_rd), 32'd0);
    chk("abort_wr_sel", 32'(o_lb_wr_sel), 32'd1);
    chk("abort_rd_sel", 32'(o_lb_rd_sel), 32'd0);

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
